// File: rtl/ime_egress_stage.sv
// ime_egress_stage: final stage of the IME datapath, driving the m_axis stream.
//
// The stage buffers beats in an output register plus one skid register, which
// keeps s_axis_tready registered without losing throughput. It zeroes m_axis_tdata
// while poisoned. Downstream credits gate m_axis_tvalid, and so does a running BIST.
// Error flags are sticky.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   s_axis_*            upstream stream (tdata, tuser, tvalid, tready, tlast)
//   m_axis_*            downstream stream (tdata, tuser, tvalid, tready, tlast)
//   credit_return       one-cycle pulse returning one downstream credit
//   poison_in/clr       pulses that set / clear the sticky poison state
//   bist_status         00 IDLE, 01 RUNNING, 10 PASS, 11 FAIL
//   err_clr             write-one-to-clear for error_flags
//   poison_flag         sticky poison state
//   error_flags         [0] credit overflow, [1] poison raised,
//                       [2] BIST fail, [3] tlast mode field not onehot
//   credit_depth        credits currently available downstream
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | normal streaming; s_axis_tready = !skid_valid
// HOLD    | BIST running; intake stopped, buffered beats retained
// RESUME  | one cycle after BIST ends; re-arms s_axis_tready
module ime_egress_stage #(
    parameter int W_ACC        = 32,
    parameter int W_USER       = 8,
    parameter int MODE_LSB     = 0,
    parameter int MODE_WIDTH   = 3,
    parameter int CREDIT_WIDTH = 16,
    parameter int CREDIT_INIT  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [W_ACC-1:0]        s_axis_tdata,
    input  logic [W_USER-1:0]       s_axis_tuser,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [W_ACC-1:0]        m_axis_tdata,
    output logic [W_USER-1:0]       m_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    input  logic                    credit_return,
    input  logic                    poison_in,
    input  logic                    poison_clr,
    input  logic [1:0]              bist_status,
    input  logic [3:0]              err_clr,
    output logic                    poison_flag,
    output logic [3:0]              error_flags,
    output logic [CREDIT_WIDTH-1:0] credit_depth
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RESUME = 2'd2
    } state_t;

    localparam logic [1:0]              BIST_RUNNING = 2'b01;
    localparam logic [1:0]              BIST_FAIL    = 2'b11;
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX   = '1;
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_RST   = CREDIT_WIDTH'(CREDIT_INIT);

    state_t                  state;
    state_t                  state_nxt;
    logic                    ready_r;
    logic                    out_valid;
    logic [W_ACC-1:0]        out_data;
    logic [W_USER-1:0]       out_user;
    logic                    out_last;
    logic                    skid_valid;
    logic                    skid_valid_nxt;
    logic [W_ACC-1:0]        skid_data;
    logic [W_USER-1:0]       skid_user;
    logic                    skid_last;
    logic [CREDIT_WIDTH-1:0] credit_cnt;
    logic                    poison_r;
    logic [3:0]              err_r;
    logic [3:0]              err_set;

    logic                    bist_running;
    logic                    bist_fail_exit;
    logic                    poison_set;
    logic                    m_valid;
    logic                    m_fire;
    logic                    s_fire;
    logic                    out_load;
    logic [MODE_WIDTH-1:0]   mode_field;
    logic                    mode_onehot;

    assign bist_running   = (bist_status == BIST_RUNNING);
    assign bist_fail_exit = (state == ST_HOLD) && (bist_status == BIST_FAIL);
    assign poison_set     = poison_in | bist_fail_exit;

    // The BIST term stays combinational so that valid drops in the same cycle BIST starts.
    assign m_valid  = out_valid & (credit_cnt != '0) & ~bist_running;
    assign m_fire   = m_valid & m_axis_tready;
    assign s_fire   = s_axis_tvalid & ready_r;
    assign out_load = ~out_valid | m_fire;

    assign mode_field  = s_axis_tuser[MODE_LSB +: MODE_WIDTH];
    assign mode_onehot = (mode_field != '0) &&
                         ((mode_field & (mode_field - MODE_WIDTH'(1))) == '0);

    // Because ready is registered as !skid_valid, an accept never coincides
    // with a full skid. So when the output register frees up, the skid always empties.
    assign skid_valid_nxt = out_load ? 1'b0 : (skid_valid | s_fire);

    assign err_set[0] = credit_return & ~m_fire & (credit_cnt == CREDIT_MAX);
    assign err_set[1] = poison_set & ~poison_r;
    assign err_set[2] = bist_fail_exit;
    assign err_set[3] = s_fire & s_axis_tlast & ~mode_onehot;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (bist_running) state_nxt = ST_HOLD;
            ST_HOLD:   if (!bist_running) state_nxt = ST_RESUME;
            ST_RESUME: state_nxt = bist_running ? ST_HOLD : ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            ready_r <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_r <= (state_nxt == ST_RUN) & ~skid_valid_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_user   <= '0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_user  <= '0;
            skid_last  <= 1'b0;
        end else begin
            skid_valid <= skid_valid_nxt;
            if (out_load) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                    out_user  <= skid_user;
                    out_last  <= skid_last;
                end else if (s_fire) begin
                    out_valid <= 1'b1;
                    out_data  <= s_axis_tdata;
                    out_user  <= s_axis_tuser;
                    out_last  <= s_axis_tlast;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (s_fire) begin
                skid_data <= s_axis_tdata;
                skid_user <= s_axis_tuser;
                skid_last <= s_axis_tlast;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CREDIT_RST;
            poison_r   <= 1'b0;
            err_r      <= '0;
        end else begin
            case ({m_fire, credit_return})
                2'b10:   credit_cnt <= credit_cnt - 1'b1;
                2'b01:   if (credit_cnt != CREDIT_MAX) credit_cnt <= credit_cnt + 1'b1;
                default: credit_cnt <= credit_cnt;
            endcase
            if (poison_set)
                poison_r <= 1'b1;
            else if (poison_clr)
                poison_r <= 1'b0;
            err_r <= (err_r & ~err_clr) | err_set;
        end
    end

    assign s_axis_tready = ready_r;
    assign m_axis_tvalid = m_valid;
    assign m_axis_tdata  = poison_r ? '0 : out_data;
    assign m_axis_tuser  = out_user;
    assign m_axis_tlast  = out_last;
    assign poison_flag   = poison_r;
    assign error_flags   = err_r;
    assign credit_depth  = credit_cnt;

endmodule

// File: tb/tb_ime_egress_stage.sv
// Testbench for ime_egress_stage. It runs directed scenarios and then a
// randomized run. A transaction-level reference model checks both: a queue
// of accepted beats, a credit count, the poison/error state and the BIST phase.
module tb_ime_egress_stage;

    localparam int W_ACC  = 32;
    localparam int W_USER = 8;
    localparam int CW     = 16;
    localparam int CINIT  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [W_ACC-1:0]  s_axis_tdata;
    logic [W_USER-1:0] s_axis_tuser;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [W_ACC-1:0]  m_axis_tdata;
    logic [W_USER-1:0] m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              credit_return;
    logic              poison_in;
    logic              poison_clr;
    logic [1:0]        bist_status;
    logic [3:0]        err_clr;
    logic              poison_flag;
    logic [3:0]        error_flags;
    logic [CW-1:0]     credit_depth;

    always #5 clk = ~clk;

    ime_egress_stage #(
        .W_ACC(W_ACC), .W_USER(W_USER), .MODE_LSB(0), .MODE_WIDTH(3),
        .CREDIT_WIDTH(CW), .CREDIT_INIT(CINIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .credit_return(credit_return), .poison_in(poison_in), .poison_clr(poison_clr),
        .bist_status(bist_status), .err_clr(err_clr),
        .poison_flag(poison_flag), .error_flags(error_flags), .credit_depth(credit_depth)
    );

    typedef struct {
        logic [W_ACC-1:0]  d;
        logic [W_USER-1:0] u;
        logic              l;
    } beat_t;

    typedef enum int {P_RUN, P_HOLD, P_RESUME} phase_t;

    beat_t      q[$];
    int         m_credits;
    bit         m_poison;
    bit [3:0]   m_err;
    bit         m_ready;
    phase_t     m_phase;

    int passes = 0;
    int fails  = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_credits = CINIT;
        m_poison  = 1'b0;
        m_err     = '0;
        m_ready   = 1'b0;
        m_phase   = P_RUN;
    endtask

    // Called at a falling edge once the inputs are driven. It checks the
    // outputs, advances the model across the next rising edge, and returns
    // at the following falling edge.
    task automatic cycle();
        bit       ev;
        bit       mf;
        bit       sf;
        bit       set_p;
        bit [3:0] es;
        #1;
        ev = (q.size() != 0) && (m_credits != 0) && (bist_status != 2'b01);
        chk("tvalid", {63'd0, m_axis_tvalid}, {63'd0, ev});
        chk("s_tready", {63'd0, s_axis_tready}, {63'd0, m_ready});
        chk("credit_depth", 64'(credit_depth), 64'(m_credits));
        chk("poison_flag", {63'd0, poison_flag}, {63'd0, m_poison});
        chk("error_flags", 64'(error_flags), 64'(m_err));
        if (q.size() != 0) begin
            chk("tdata", 64'(m_axis_tdata), m_poison ? 64'd0 : 64'(q[0].d));
            chk("tuser", 64'(m_axis_tuser), 64'(q[0].u));
            chk("tlast", {63'd0, m_axis_tlast}, {63'd0, q[0].l});
        end
        mf = ev && m_axis_tready;
        sf = s_axis_tvalid && m_ready;
        es = '0;
        if (mf) void'(q.pop_front());
        if (sf) begin
            q.push_back('{d: s_axis_tdata, u: s_axis_tuser, l: s_axis_tlast});
            if (s_axis_tlast && $countones(s_axis_tuser[2:0]) != 1) es[3] = 1'b1;
        end
        if (mf && !credit_return) m_credits--;
        else if (credit_return && !mf) begin
            if (m_credits == 65535) es[0] = 1'b1;
            else m_credits++;
        end
        set_p = poison_in || (m_phase == P_HOLD && bist_status == 2'b11);
        if (m_phase == P_HOLD && bist_status == 2'b11) es[2] = 1'b1;
        if (set_p && !m_poison) es[1] = 1'b1;
        if (set_p) m_poison = 1'b1;
        else if (poison_clr) m_poison = 1'b0;
        m_err = (m_err & ~err_clr) | es;
        case (m_phase)
            P_RUN:    if (bist_status == 2'b01) m_phase = P_HOLD;
            P_HOLD:   if (bist_status != 2'b01) m_phase = P_RESUME;
            default:  m_phase = (bist_status == 2'b01) ? P_HOLD : P_RUN;
        endcase
        m_ready = (m_phase == P_RUN) && (q.size() < 2);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic refill(input int n);
        credit_return = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        credit_return = 1'b0;
    endtask

    task automatic push(input logic [W_ACC-1:0] d, input logic [W_USER-1:0] u, input logic l);
        bit acc;
        acc = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = m_ready;
            cycle();
        end
        s_axis_tvalid = 1'b0;
        chk("push_accepted", {63'd0, acc}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst_n = 1'b0;
        s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0; credit_return = 1'b0; poison_in = 1'b0; poison_clr = 1'b0;
        bist_status = 2'b00; err_clr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_tready", {63'd0, s_axis_tready}, 64'd0);
        chk("rst_credit", 64'(credit_depth), 64'(CINIT));
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // 1: four back-to-back beats
        m_axis_tready = 1'b1;
        push(32'h11, 8'h01, 1'b0);
        #1 chk("t1_latency", {63'd0, m_axis_tvalid}, 64'd1);
        push(32'h12, 8'h01, 1'b0);
        push(32'h13, 8'h01, 1'b0);
        push(32'h14, 8'h01, 1'b1);
        idle(3);
        chk("t1_credit", 64'(credit_depth), 64'd4);
        chk("t1_err", 64'(error_flags), 64'd0);

        // 2: credit exhaustion, single return, simultaneous return and handshake
        for (int i = 0; i < 6; i++) push(32'h21 + 32'(i), 8'h02, 1'b0);
        idle(3);
        chk("t2_hold_valid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("t2_hold_data", 64'(m_axis_tdata), 64'h25);
        chk("t2_hold_ready", {63'd0, s_axis_tready}, 64'd0);
        credit_return = 1'b1; cycle();
        credit_return = 1'b0; cycle();
        #1 chk("t2_after_return", 64'(credit_depth), 64'd0);
        credit_return = 1'b1; cycle();
        cycle();
        credit_return = 1'b0;
        #1 chk("t2_simultaneous", 64'(credit_depth), 64'd1);
        refill(7);

        // 3: poison mid-stream
        push(32'hDEADBEEF, 8'h11, 1'b0);
        push(32'hDEADBEEF, 8'h12, 1'b0);
        poison_in = 1'b1;
        push(32'hDEADBEEF, 8'h02, 1'b1);
        poison_in = 1'b0;
        #1;
        chk("t3_tdata_zero", 64'(m_axis_tdata), 64'd0);
        chk("t3_tlast_pass", {63'd0, m_axis_tlast}, 64'd1);
        chk("t3_tuser_pass", 64'(m_axis_tuser), 64'h02);
        chk("t3_poison", {63'd0, poison_flag}, 64'd1);
        chk("t3_err1", {63'd0, error_flags[1]}, 64'd1);
        poison_clr = 1'b1;
        push(32'hDEADBEEF, 8'h13, 1'b0);
        poison_clr = 1'b0;
        #1 chk("t3_data_resumed", 64'(m_axis_tdata), 64'hDEADBEEF);
        err_clr = 4'b0010; cycle(); err_clr = '0;
        idle(2);
        refill(8);

        // 4: BIST preemption, PASS then FAIL
        m_axis_tready = 1'b0;
        push(32'hB1, 8'h04, 1'b0);
        bist_status = 2'b01;
        #1 chk("t4_valid_blocked", {63'd0, m_axis_tvalid}, 64'd0);
        cycle();
        #1 chk("t4_ready_hold", {63'd0, s_axis_tready}, 64'd0);
        idle(2);
        bist_status = 2'b10; cycle();
        #1 chk("t4_ready_resume", {63'd0, s_axis_tready}, 64'd0);
        cycle();
        #1 chk("t4_ready_run", {63'd0, s_axis_tready}, 64'd1);
        chk("t4_data_kept", 64'(m_axis_tdata), 64'hB1);
        m_axis_tready = 1'b1; cycle(); m_axis_tready = 1'b0;
        push(32'hB2, 8'h04, 1'b0);
        bist_status = 2'b01; idle(3);
        bist_status = 2'b11; cycle();
        #1;
        chk("t4_fail_poison", {63'd0, poison_flag}, 64'd1);
        chk("t4_fail_err2", {63'd0, error_flags[2]}, 64'd1);
        bist_status = 2'b00; idle(2);
        m_axis_tready = 1'b1; idle(1);
        poison_clr = 1'b1; err_clr = 4'hF; cycle();
        poison_clr = 1'b0; err_clr = '0;
        refill(8);

        // 5: EXACT1 mode field on tlast
        push(32'h55, 8'h03, 1'b1);
        #1;
        chk("t5_err3", {63'd0, error_flags[3]}, 64'd1);
        chk("t5_forwarded", 64'(m_axis_tdata), 64'h55);
        err_clr = 4'b1000; cycle(); err_clr = '0;
        #1 chk("t5_cleared", 64'(error_flags), 64'd0);
        push(32'h66, 8'h04, 1'b1);
        idle(1);
        chk("t5_onehot_ok", 64'(error_flags), 64'd0);
        refill(4);

        // 6: reset mid-frame with both entries full
        m_axis_tready = 1'b0;
        push(32'h71, 8'h01, 1'b0);
        push(32'h72, 8'h01, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("t6_tdata", 64'(m_axis_tdata), 64'd0);
        chk("t6_tuser", 64'(m_axis_tuser), 64'd0);
        chk("t6_tlast", {63'd0, m_axis_tlast}, 64'd0);
        chk("t6_tready", {63'd0, s_axis_tready}, 64'd0);
        chk("t6_credit", 64'(credit_depth), 64'(CINIT));
        chk("t6_err", 64'(error_flags), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        idle(4);
        chk("t6_no_stale", {63'd0, m_axis_tvalid}, 64'd0);

        // randomized run against the model
        acc = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if (!s_axis_tvalid || acc) begin
                s_axis_tvalid = 1'($urandom_range(0, 1));
                s_axis_tdata  = $urandom;
                s_axis_tuser  = 8'($urandom_range(0, 255));
                s_axis_tlast  = ($urandom_range(0, 3) == 0);
            end
            m_axis_tready = ($urandom_range(0, 3) != 0);
            credit_return = ($urandom_range(0, 2) == 0);
            poison_in     = ($urandom_range(0, 31) == 0);
            poison_clr    = ($urandom_range(0, 7) == 0);
            err_clr       = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'd0;
            if ($urandom_range(0, 19) == 0) bist_status = 2'($urandom_range(0, 3));
            acc = s_axis_tvalid && m_ready;
            cycle();
        end
        s_axis_tvalid = 1'b0; credit_return = 1'b0; poison_in = 1'b0;
        poison_clr = 1'b0; err_clr = '0; bist_status = 2'b00;
        idle(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
